bus_arbiter_2m: RTL and testbench
=================================

# bus_arbiter_2m

Two-master, one-slave arbiter for the core's native master bus protocol (bstart/bdone handshake). It shares a single-ported memory/peripheral slave between the core's `dbus` (master 0) and `ibus` (master 1). Arbitration is round-robin, with one-deep handoff between masters and a watchdog that terminates hung transactions with an error. It sits between `rv_core` and any slave that lacks a second port.

## Interface
- `TIMEOUT`, default 1024: number of BUSY cycles without `s_bdone` before a forced error completion; 0 disables the watchdog.
- `clk`  in  1  — single clock; everything is on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `mN_breq`  in  1  — master N bus request qualifier (N = 0, 1).
- `mN_bstart`  in  1  — master N transaction request; held high until `mN_bdone`.
- `mN_ttype`  in  ttype_e  — READ/WRITE (bus_if_types_pkg).
- `mN_tsize`  in  tsize_e  — BYTE/HALF/WORD (bus_if_types_pkg).
- `mN_addr`  in  32  — byte address.
- `mN_wdata`  in  32  — write data.
- `mN_rdata`  out  32  — read data; valid only while `mN_bdone` = 1.
- `mN_bdone`  out  1  — one-cycle completion pulse to master N.
- `mN_berr`  out  1  — one-cycle error flag, coincident with `mN_bdone` on timeout.
- `s_breq`, `s_bstart`, `s_ttype`, `s_tsize`, `s_addr`, `s_wdata`  out  1/1/ttype_e/tsize_e/32/32 — slave-side request.
- `s_rdata`  in  32  — slave read data.
- `s_bdone`  in  1  — slave completion pulse.

## Operation
- Request for master N: `reqN = mN_breq & mN_bstart`.
- State machine states: IDLE, BUSY0, BUSY1.
- Registers:
  - `state`.
  - `last_grant` (1 bit): reset value 1, so master 0 wins the first tie.
  - `wd_cnt` (16 bits): watchdog counter.
- IDLE transitions:
  - Only `req0` → BUSY0. Only `req1` → BUSY1.
  - Both → BUSY of the master that is not `last_grant`.
  - Neither → stay in IDLE.
- On entering BUSYN: `last_grant` ← N, `wd_cnt` ← 0.
- In BUSYN:
  - Slave outputs mirror master N's fields.
  - `s_bstart` = 1 and `s_breq` = 1.
  - `mN_rdata` = `s_rdata`, `mN_bdone` = `s_bdone`.
  - The other master sees `bdone` = 0, `berr` = 0, `rdata` = 0.
- Completion in BUSYN (`s_bdone` = 1, or a watchdog expiry):
  - If the other master is requesting → go directly to BUSY(other). This is the handoff; no IDLE cycle.
  - Otherwise → IDLE.
  - Never re-grant N directly from BUSYN. Its `bstart` is stale in the `bdone` cycle.
- Watchdog (`TIMEOUT` ≠ 0):
  - `wd_cnt` increments each BUSY cycle without `s_bdone`.
  - When `wd_cnt == TIMEOUT-1` and `s_bdone` = 0: `mN_bdone` = 1 and `mN_berr` = 1 for that cycle, `mN_rdata` = 0, and the transaction is treated as completed.
  - A late `s_bdone` arriving while in IDLE is ignored. A late `s_bdone` arriving during a new grant is accepted and credited to the new grant; slaves must not respond after a timeout.
- A master dropping `bstart` mid-BUSY does not abort the transaction. The arbiter waits for `s_bdone` (or the timeout) and still pulses `bdone`.
- In IDLE, all slave outputs are 0 and `s_ttype` = READ.
- Reset (any time, including mid-transaction):
  - `state` = IDLE, `last_grant` = 1, `wd_cnt` = 0.
  - All outputs 0 / READ immediately, since they are combinational from the reset state.
  - The in-flight slave transaction is abandoned.

## Timing
- Grant latency: request sampled high in IDLE at edge t → `s_bstart` = 1 in cycle t+1.
- Slave outputs are combinational from the registered `state`, so `s_*` changes only at clock edges plus master-input changes.
- `bdone`/`rdata` pass through combinationally in the same cycle as `s_bdone`. The arbiter adds zero response latency.
- Handoff: `s_bdone` for M0 in cycle k → `s_bstart` stays 1 with M1's fields in cycle k+1.
- Minimum transaction occupancy: one BUSY cycle, when the slave returns `bdone` in the first cycle.
- The watchdog fires in the TIMEOUT-th BUSY cycle of a grant; `s_bstart` drops (or switches master) on the next edge.

## Test plan
- Single fetch: M1 reads 0x0000_0100, slave returns 0xDEAD_BEEF with `bdone` 2 cycles after `s_bstart` → `s_addr` = 0x100 one cycle after the request; `m1_rdata` = 0xDEAD_BEEF with `m1_bdone` = 1 for exactly 1 cycle; M0 sees nothing.
- Simultaneous first request after reset: M0 WORD write of 0x1234_5678 to 0x2000, and M1 read → M0 granted first; M1 handed off in the cycle right after M0's `bdone`; `last_grant` ends at 1.
- Fairness: both masters request continuously for 6 transactions → grants strictly alternate 0,1,0,1,0,1.
- Watchdog: `TIMEOUT` = 8, slave never responds to M0 → `m0_bdone` = 1 and `m0_berr` = 1 in the 8th BUSY cycle; state returns to IDLE; `s_bstart` = 0 next cycle.
- `TIMEOUT` = 0, slave silent for 5000 cycles → no `berr`; the arbiter remains in BUSY.
- Reset asserted mid-BUSY1 → `s_bstart`, `m1_bdone` and `s_addr` go to 0 asynchronously; after release, a tied request grants M0.

Source files
------------

// File: rtl/bus_arbiter_2m.sv
// bus_if_types_pkg: transfer type and size encodings of the core's native
// master bus protocol.
//
// bus_arbiter_2m: shares one single-ported slave between two bstart/bdone
// masters (m0 = dbus, m1 = ibus).
//   clk, rst            : clock, asynchronous active-high reset
//   mN_breq, mN_bstart  : master N request qualifier / transaction request
//   mN_ttype, mN_tsize  : master N transfer type / size
//   mN_addr, mN_wdata   : master N byte address / write data
//   mN_rdata            : read data to master N (valid with mN_bdone)
//   mN_bdone, mN_berr   : completion pulse / watchdog error flag to master N
//   s_*                 : slave-side request fields, s_rdata / s_bdone back
// Round-robin arbitration with direct handoff to a waiting master, and a
// watchdog that force-completes a grant with an error after TIMEOUT busy
// cycles (TIMEOUT = 0 disables it).

package bus_if_types_pkg;
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ttype_e;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } tsize_e;
endpackage

module bus_arbiter_2m
   import bus_if_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        m0_breq,
   input  logic        m0_bstart,
   input  ttype_e      m0_ttype,
   input  tsize_e      m0_tsize,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_bdone,
   output logic        m0_berr,

   input  logic        m1_breq,
   input  logic        m1_bstart,
   input  ttype_e      m1_ttype,
   input  tsize_e      m1_tsize,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_bdone,
   output logic        m1_berr,

   output logic        s_breq,
   output logic        s_bstart,
   output ttype_e      s_ttype,
   output tsize_e      s_tsize,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_bdone
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY0 = 2'b01,
      BUSY1 = 2'b10
   } state_e;

   localparam bit          WD_EN   = (TIMEOUT != 0);
   // Only meaningful when WD_EN is set; the wrap for TIMEOUT = 0 is unused.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_e      state;
   logic        last_grant;
   logic [15:0] wd_cnt;

   logic        req0;
   logic        req1;
   logic        busy;
   logic        wd_fire;
   logic        xfer_done;

   assign req0      = m0_breq & m0_bstart;
   assign req1      = m1_breq & m1_bstart;
   assign busy      = (state != IDLE);
   assign wd_fire   = WD_EN && busy && (wd_cnt == WD_LAST) && !s_bdone;
   assign xfer_done = busy && (s_bdone || wd_fire);

   // Completion never re-grants the same master: its bstart is still high
   // in the bdone cycle, so it must pass through IDLE first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 && (!req1 || last_grant)) begin
                  state      <= BUSY0;
                  last_grant <= 1'b0;
                  wd_cnt     <= '0;
               end else if (req1) begin
                  state      <= BUSY1;
                  last_grant <= 1'b1;
                  wd_cnt     <= '0;
               end
            end
            BUSY0: begin
               if (xfer_done) begin
                  if (req1) begin
                     state      <= BUSY1;
                     last_grant <= 1'b1;
                     wd_cnt     <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            BUSY1: begin
               if (xfer_done) begin
                  if (req0) begin
                     state      <= BUSY0;
                     last_grant <= 1'b0;
                     wd_cnt     <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_breq   = 1'b0;
      s_bstart = 1'b0;
      s_ttype  = READ;
      s_tsize  = BYTE;
      s_addr   = '0;
      s_wdata  = '0;
      m0_rdata = '0;
      m0_bdone = 1'b0;
      m0_berr  = 1'b0;
      m1_rdata = '0;
      m1_bdone = 1'b0;
      m1_berr  = 1'b0;
      case (state)
         BUSY0: begin
            s_breq   = 1'b1;
            s_bstart = 1'b1;
            s_ttype  = m0_ttype;
            s_tsize  = m0_tsize;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            m0_rdata = wd_fire ? '0 : s_rdata;
            m0_bdone = s_bdone | wd_fire;
            m0_berr  = wd_fire;
         end
         BUSY1: begin
            s_breq   = 1'b1;
            s_bstart = 1'b1;
            s_ttype  = m1_ttype;
            s_tsize  = m1_tsize;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            m1_rdata = wd_fire ? '0 : s_rdata;
            m1_bdone = s_bdone | wd_fire;
            m1_berr  = wd_fire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Testbench for bus_arbiter_2m: randomized two-master traffic against a
// transaction-level reference of the arbitration rules, a slave model with
// random latency (occasionally silent, to trip the watchdog), a completion
// scoreboard, directed reset/handoff checks, and a watchdog-disabled
// instance left hanging for 5000 cycles.

module tb_bus_arbiter_2m;
   import bus_if_types_pkg::*;

   localparam int unsigned TO  = 8;
   localparam int          NTX = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        m0_breq, m0_bstart, m1_breq, m1_bstart;
   ttype_e      m0_ttype, m1_ttype, s_ttype;
   tsize_e      m0_tsize, m1_tsize, s_tsize;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        m0_bdone, m0_berr, m1_bdone, m1_berr;
   logic        s_breq, s_bstart, s_bdone;
   logic [31:0] s_addr, s_wdata, s_rdata;

   bus_arbiter_2m #(.TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst),
      .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone), .m0_berr(m0_berr),
      .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone), .m1_berr(m1_berr),
      .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone)
   );

   // Watchdog-disabled instance.
   logic        z_rst = 1'b1;
   logic        z_m0_breq = 1'b0, z_m0_bstart = 1'b0, z_m1_breq = 1'b0, z_m1_bstart = 1'b0;
   ttype_e      z_m0_ttype = READ, z_m1_ttype = READ, z_s_ttype;
   tsize_e      z_m0_tsize = WORD, z_m1_tsize = WORD, z_s_tsize;
   logic [31:0] z_m0_addr = '0, z_m0_wdata = '0, z_m1_addr = '0, z_m1_wdata = '0;
   logic [31:0] z_m0_rdata, z_m1_rdata, z_s_addr, z_s_wdata;
   logic [31:0] z_s_rdata = 32'h0BAD_F00D;
   logic        z_m0_bdone, z_m0_berr, z_m1_bdone, z_m1_berr, z_s_breq, z_s_bstart;
   logic        z_s_bdone = 1'b0;
   bit          z_done = 1'b0;

   bus_arbiter_2m #(.TIMEOUT(0)) u_dut_nowd (
      .clk(clk), .rst(z_rst),
      .m0_breq(z_m0_breq), .m0_bstart(z_m0_bstart), .m0_ttype(z_m0_ttype), .m0_tsize(z_m0_tsize),
      .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_rdata(z_m0_rdata), .m0_bdone(z_m0_bdone), .m0_berr(z_m0_berr),
      .m1_breq(z_m1_breq), .m1_bstart(z_m1_bstart), .m1_ttype(z_m1_ttype), .m1_tsize(z_m1_tsize),
      .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_rdata(z_m1_rdata), .m1_bdone(z_m1_bdone), .m1_berr(z_m1_berr),
      .s_breq(z_s_breq), .s_bstart(z_s_bstart), .s_ttype(z_s_ttype), .s_tsize(z_s_tsize),
      .s_addr(z_s_addr), .s_wdata(z_s_wdata), .s_rdata(z_s_rdata), .s_bdone(z_s_bdone)
   );

   int          tests = 0;
   int          fails = 0;
   bit          chk_en = 1'b0;
   bit          slave_en = 1'b0;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   // Slave read data is a fixed function of the address it was given.
   function automatic logic [31:0] slv_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int n, input logic breq, input logic bstart, input ttype_e tt,
                        input tsize_e ts, input logic [31:0] a, input logic [31:0] d);
      if (n == 0) begin
         m0_breq = breq; m0_bstart = bstart; m0_ttype = tt; m0_tsize = ts; m0_addr = a; m0_wdata = d;
      end else begin
         m1_breq = breq; m1_bstart = bstart; m1_ttype = tt; m1_tsize = ts; m1_addr = a; m1_wdata = d;
      end
   endtask

   // One randomized master: idle gaps with breq noise, transaction held until
   // bdone, occasionally dropping bstart after being granted.
   task automatic run_master(input int n);
      logic [31:0] a, d;
      ttype_e      tt;
      tsize_e      ts;
      int          gap, waitc;
      bit          seen, dropped;
      for (int i = 0; i < NTX; i++) begin
         gap = (i == 0) ? 0 : int'($urandom_range(3));
         for (int g = 0; g < gap; g++) begin
            drive(n, 1'($urandom_range(1)), 1'b0, READ, BYTE, $urandom, $urandom);
            @(posedge clk); #1;
         end
         a  = {(n == 1), 31'($urandom)};
         d  = $urandom;
         tt = ttype_e'($urandom_range(1));
         ts = tsize_e'($urandom_range(2));
         if (n == 0) exp_q0.push_back(slv_data(a));
         else        exp_q1.push_back(slv_data(a));
         drive(n, 1'b1, 1'b1, tt, ts, a, d);
         waitc = 0; seen = 1'b0; dropped = 1'b0;
         while (!seen && waitc < 100) begin
            @(negedge clk);
            waitc++;
            if ((n == 0) ? m0_bdone : m1_bdone) begin
               seen = 1'b1;
            end else if (!dropped && s_bstart && s_addr == a && $urandom_range(7) == 0) begin
               @(posedge clk); #1;
               drive(n, 1'b1, 1'b0, tt, ts, a, d);
               dropped = 1'b1;
            end
         end
         if (!seen) begin
            tests++; fails++;
            $display("FAIL m%0d_bdone_wait: got no bdone in 100 cycles, expected one", n);
         end
         @(posedge clk); #1;
         drive(n, 1'b0, 1'b0, tt, ts, a, d);
      end
   endtask

   // Slave model: random 0..3 cycle latency, 1 in 6 transactions never
   // answered, spurious bdone pulses while no request is presented.
   initial begin
      logic prev_bs, prev_done;
      bit   silent;
      int   lat, cnt;
      prev_bs = 1'b0; prev_done = 1'b0; silent = 1'b0; lat = 0; cnt = 0;
      s_bdone = 1'b0; s_rdata = '0;
      forever begin
         @(posedge clk); #2;
         if (!slave_en) begin
            s_bdone = 1'b0;
            s_rdata = '0;
         end else if (s_bstart) begin
            if (!prev_bs || prev_done) begin
               silent = ($urandom_range(5) == 0);
               lat    = int'($urandom_range(3));
               cnt    = 0;
            end
            s_bdone = !silent && (cnt == lat);
            s_rdata = slv_data(s_addr);
            cnt++;
         end else begin
            s_bdone = ($urandom_range(9) == 0);
            s_rdata = $urandom;
         end
         @(negedge clk);
         prev_bs   = s_bstart;
         prev_done = m0_bdone | m1_bdone;
      end
   end

   // Reference of the arbitration rules: who owns the slave this cycle, how
   // long they have held it, and who must get it next.
   initial begin
      int owner, busy, pick;
      bit last, rq0, rq1, exp_err, exp_done;
      owner = -1; busy = 0; last = 1'b1;
      forever begin
         @(negedge clk);
         if (!chk_en) begin
            owner = -1; busy = 0; last = 1'b1;
         end else begin
            rq0      = m0_breq & m0_bstart;
            rq1      = m1_breq & m1_bstart;
            exp_err  = (owner >= 0) && (busy == int'(TO)) && !s_bdone;
            exp_done = (owner >= 0) && (s_bdone || exp_err);
            check("s_bstart", {31'b0, s_bstart}, {31'b0, owner >= 0});
            if (owner < 0) begin
               check("s_addr_idle", s_addr, 32'h0);
               check("s_ctrl_idle", {28'b0, s_breq, s_ttype, s_tsize}, {28'b0, 1'b0, READ, BYTE});
            end else begin
               check("s_addr", s_addr, (owner == 0) ? m0_addr : m1_addr);
               check("s_wdata", s_wdata, (owner == 0) ? m0_wdata : m1_wdata);
               check("s_ctrl", {28'b0, s_breq, s_ttype, s_tsize},
                     (owner == 0) ? {28'b0, 1'b1, m0_ttype, m0_tsize} : {28'b0, 1'b1, m1_ttype, m1_tsize});
            end
            check("m0_bdone_berr", {30'b0, m0_bdone, m0_berr},
                  {30'b0, exp_done && owner == 0, exp_err && owner == 0});
            check("m1_bdone_berr", {30'b0, m1_bdone, m1_berr},
                  {30'b0, exp_done && owner == 1, exp_err && owner == 1});
            if (owner != 0) check("m0_rdata_quiet", m0_rdata, 32'h0);
            if (owner != 1) check("m1_rdata_quiet", m1_rdata, 32'h0);
            if (owner < 0) begin
               if (rq0 || rq1) begin
                  pick  = (rq0 && rq1) ? (last ? 0 : 1) : (rq0 ? 0 : 1);
                  owner = pick; last = (pick == 1); busy = 1;
               end
            end else if (exp_done) begin
               if ((owner == 0) ? rq1 : rq0) begin
                  owner = 1 - owner; last = (owner == 1); busy = 1;
               end else begin
                  owner = -1;
               end
            end else begin
               busy++;
            end
         end
      end
   end

   // Completion scoreboard.
   initial begin
      logic [31:0] item;
      forever begin
         @(negedge clk);
         if (chk_en && m0_bdone) begin
            if (exp_q0.size() == 0) begin
               tests++; fails++;
               $display("FAIL m0_unexpected_bdone: got bdone, expected none pending");
            end else begin
               item = exp_q0.pop_front();
               check("m0_rdata", m0_rdata, m0_berr ? 32'h0 : item);
            end
         end
         if (chk_en && m1_bdone) begin
            if (exp_q1.size() == 0) begin
               tests++; fails++;
               $display("FAIL m1_unexpected_bdone: got bdone, expected none pending");
            end else begin
               item = exp_q1.pop_front();
               check("m1_rdata", m1_rdata, m1_berr ? 32'h0 : item);
            end
         end
      end
   end

   // Watchdog disabled: a silent slave leaves the grant hanging.
   initial begin
      int bad;
      bad = 0;
      repeat (2) @(negedge clk);
      z_rst = 1'b0;
      @(posedge clk); #1;
      z_m0_breq = 1'b1; z_m0_bstart = 1'b1; z_m0_addr = 32'h40;
      @(posedge clk); @(negedge clk);
      check("nowd_grant", {31'b0, z_s_bstart}, 32'h1);
      repeat (5000) begin
         @(negedge clk);
         if (z_m0_bdone || z_m0_berr || !z_s_bstart) bad++;
      end
      check("nowd_hang_cycles_bad", bad, 32'h0);
      z_done = 1'b1;
   end

   initial begin
      drive(0, 1'b0, 1'b0, READ, BYTE, '0, '0);
      drive(1, 1'b0, 1'b0, READ, BYTE, '0, '0);
      #3;
      check("reset_s_bstart", {31'b0, s_bstart}, 32'h0);
      check("reset_s_ctrl", {28'b0, s_breq, s_ttype, s_tsize}, {28'b0, 1'b0, READ, BYTE});
      check("reset_m_done", {28'b0, m0_bdone, m0_berr, m1_bdone, m1_berr}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0; chk_en = 1'b1; slave_en = 1'b1;
      @(posedge clk); #1;
      fork
         run_master(0);
         run_master(1);
      join
      repeat (3) @(negedge clk);
      check("q0_drained", exp_q0.size(), 32'h0);
      check("q1_drained", exp_q1.size(), 32'h0);
      chk_en = 1'b0; slave_en = 1'b0;
      repeat (2) @(posedge clk);

      // Grant latency, asynchronous reset mid-BUSY1, tie after reset, handoff.
      #1;
      drive(1, 1'b1, 1'b1, READ, WORD, 32'h0000_0100, '0);
      @(posedge clk); @(negedge clk);
      check("m1_grant_addr", s_addr, 32'h0000_0100);
      check("m1_grant_bstart", {31'b0, s_bstart}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_s_bstart", {31'b0, s_bstart}, 32'h0);
      check("async_rst_s_addr", s_addr, 32'h0);
      check("async_rst_m1_bdone", {31'b0, m1_bdone}, 32'h0);
      drive(0, 1'b1, 1'b1, WRITE, WORD, 32'h0000_2000, 32'h1234_5678);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("tie_after_rst_addr", s_addr, 32'h0000_2000);
      check("tie_after_rst_wdata", s_wdata, 32'h1234_5678);
      #1;
      s_rdata = 32'hDEAD_BEEF; s_bdone = 1'b1;
      #1;
      check("m0_done_passthru", {30'b0, m0_bdone, m1_bdone}, 32'h2);
      check("m0_rdata_passthru", m0_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, READ, BYTE, '0, '0);
      @(negedge clk);
      check("handoff_addr", s_addr, 32'h0000_0100);
      check("handoff_bstart", {31'b0, s_bstart}, 32'h1);
      rst = 1'b1;
      drive(1, 1'b0, 1'b0, READ, BYTE, '0, '0);

      for (int i = 0; i < 10000 && !z_done; i++) @(posedge clk);
      if (!z_done) begin
         tests++; fails++;
         $display("FAIL nowd_finish: got no completion of hang test, expected completion");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
